// File: rtl/ccc_apb_cfg_master_if.sv
// Signal bundle between a fabric controller, the CCC dynamic-configuration APB
// port and the ccc_apb_cfg_master initiator.
interface ccc_apb_cfg_master_if;
  // Command side: a command transfers on a rising edge where cmd_valid & cmd_ready.
  // cmd_valid may be raised at any time and is only looked at in IDLE.
  // rsp_valid is a single-cycle pulse with no back-pressure.
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_relock;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       pll_locked;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       BUSY;
  logic       LOCK;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_relock, PRDATA, BUSY, LOCK,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, pll_locked,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_relock, PRDATA, BUSY, LOCK,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, pll_locked,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the CCC/PLL dynamic-configuration port: one command at a
// time, optional settle + re-lock wait with timeout after the access.
module ccc_apb_cfg_master #(
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  ccc_apb_cfg_master_if.master        cfg,
  output logic [2:0]                  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_SETTLE    = 3'd3,
    S_WAIT_LOCK = 3'd4,
    S_RESP      = 3'd5
  } state_e;

  localparam int LT_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_W = (LT_W > ST_W) ? LT_W : ST_W;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [SYNC_STAGES-1:0] r_busy_sync, r_lock_sync;
  logic                   w_busy_s, w_lock_s;
  logic                   w_accept;
  logic                   w_err_nxt;

  logic       r_cmd_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic       r_psel;
  logic       r_penable;
  logic       r_pwrite;
  logic [5:0] r_paddr;
  logic [7:0] r_pwdata;
  logic       r_relock;

  assign w_busy_s = r_busy_sync[SYNC_STAGES-1];
  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_busy_sync <= '0;
      r_lock_sync <= '0;
    end else begin
      r_busy_sync <= {r_busy_sync[SYNC_STAGES-2:0], cfg.BUSY};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], cfg.LOCK};
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_rsp_err;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg.cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        w_cnt_nxt = '0;
        if (r_relock) begin
          w_state_nxt = S_SETTLE;
        end else begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock success is tested first so it wins over a same-cycle timeout.
        if (w_lock_s && !w_busy_s) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_relock    <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE) && !w_busy_s;
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_psel      <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_rsp_err   <= w_err_nxt;
      if (w_accept) begin
        r_pwrite <= cfg.cmd_write;
        r_paddr  <= cfg.cmd_addr;
        r_pwdata <= cfg.cmd_write ? cfg.cmd_wdata : 8'h00;
        r_relock <= cfg.cmd_relock;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_rdata <= r_pwrite ? 8'h00 : cfg.PRDATA;
      end
    end
  end

  assign cfg.cmd_ready  = r_cmd_ready;
  assign cfg.rsp_valid  = r_rsp_valid;
  assign cfg.rsp_rdata  = r_rsp_rdata;
  assign cfg.rsp_err    = r_rsp_err;
  assign cfg.pll_locked = w_lock_s;
  assign cfg.PSEL       = r_psel;
  assign cfg.PENABLE    = r_penable;
  assign cfg.PWRITE     = r_pwrite;
  assign cfg.PADDR      = r_paddr;
  assign cfg.PWDATA     = r_pwdata;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Directed bench for ccc_apb_cfg_master: write/read timing, relock success and
// timeout, BUSY gating and reset during an access.
module tb_ccc_apb_cfg_master;

  localparam int ST_SETTLE = 3;
  localparam int ST_WAIT   = 4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_asserts;
  int         n_fail;
  int         rv_seen;
  int         ps_seen;
  int         rdy_seen;

  ccc_apb_cfg_master_if bus ();

  ccc_apb_cfg_master #(
    .LOCK_TIMEOUT  (100),
    .SETTLE_CYCLES (16),
    .SYNC_STAGES   (2)
  ) dut (
    .PCLK        (clk),
    .PRESET      (rst),
    .cfg         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Drivers and checker
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns in the cycle after the accepting edge.
  task automatic send(input logic wr, input logic [5:0] addr, input logic [7:0] wdata,
                      input logic relock);
    int n;
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = wr;
    bus.cmd_addr   = addr;
    bus.cmd_wdata  = wdata;
    bus.cmd_relock = relock;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("send_ready_in_time", 32'(n < 50), 32'd1);
    step();
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.cmd_relock = 1'b0;
  endtask

  initial begin
    n_asserts      = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.cmd_relock = 1'b0;
    bus.PRDATA     = '0;
    bus.BUSY       = 1'b0;
    bus.LOCK       = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_psel",      bus.PSEL, 0);
    check("rst_penable",   bus.PENABLE, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_paddr",     bus.PADDR, 0);
    check("rst_state",     dbg_state, 0);
    rst = 1'b0;
    step();
    check("rel_cmd_ready", bus.cmd_ready, 1);

    // LOCK synchronizer latency
    bus.LOCK = 1'b1;
    step();
    check("lock_sync_1", bus.pll_locked, 0);
    step();
    check("lock_sync_2", bus.pll_locked, 1);

    // Plain write
    send(1'b1, 6'h05, 8'hA5, 1'b0);
    check("wr_setup_psel",    bus.PSEL, 1);
    check("wr_setup_penable", bus.PENABLE, 0);
    check("wr_setup_ready",   bus.cmd_ready, 0);
    step();
    check("wr_acc_psel",    bus.PSEL, 1);
    check("wr_acc_penable", bus.PENABLE, 1);
    check("wr_acc_paddr",   bus.PADDR, 32'h05);
    check("wr_acc_pwdata",  bus.PWDATA, 32'hA5);
    check("wr_acc_pwrite",  bus.PWRITE, 1);
    step();
    check("wr_rsp_valid", bus.rsp_valid, 1);
    check("wr_rsp_err",   bus.rsp_err, 0);
    check("wr_rsp_rdata", bus.rsp_rdata, 0);
    check("wr_rsp_psel",  bus.PSEL, 0);
    step();
    check("wr_post_valid", bus.rsp_valid, 0);
    check("wr_post_ready", bus.cmd_ready, 1);

    // Read
    send(1'b0, 6'h3F, 8'hEE, 1'b0);
    step();
    bus.PRDATA = 8'h5C;
    check("rd_acc_penable", bus.PENABLE, 1);
    check("rd_acc_pwrite",  bus.PWRITE, 0);
    check("rd_acc_pwdata",  bus.PWDATA, 0);
    check("rd_acc_paddr",   bus.PADDR, 32'h3F);
    step();
    bus.PRDATA = 8'h00;
    check("rd_rsp_valid", bus.rsp_valid, 1);
    check("rd_rsp_rdata", bus.rsp_rdata, 32'h5C);
    step();
    check("rd_post_valid", bus.rsp_valid, 0);
    check("rd_rdata_hold", bus.rsp_rdata, 32'h5C);

    // Relock success: LOCK drops 2 cycles after ACCESS, returns 40 cycles later
    send(1'b1, 6'h10, 8'h33, 1'b1);
    step();
    check("rl_acc_penable", bus.PENABLE, 1);
    rv_seen = 0;
    for (int j = 3; j <= 46; j++) begin
      step();
      if (j == 4)  bus.LOCK = 1'b0;
      if (j == 44) bus.LOCK = 1'b1;
      if (j == 3)  check("rl_settle_psel", bus.PSEL, 0);
      if (j == 18) check("rl_settle_last", dbg_state, ST_SETTLE);
      if (j == 19) check("rl_wait_first", dbg_state, ST_WAIT);
      if (bus.rsp_valid === 1'b1) rv_seen++;
    end
    check("rl_no_early_rsp", rv_seen, 0);
    step();
    check("rl_rsp_valid", bus.rsp_valid, 1);
    check("rl_rsp_err",   bus.rsp_err, 0);
    check("rl_rsp_rdata", bus.rsp_rdata, 0);
    step();
    check("rl_post_valid", bus.rsp_valid, 0);
    check("rl_post_ready", bus.cmd_ready, 1);

    // Relock timeout: LOCK held low, WAIT_LOCK lasts exactly 100 cycles
    bus.LOCK = 1'b0;
    step();
    step();
    check("to_lock_low", bus.pll_locked, 0);
    send(1'b1, 6'h01, 8'h0F, 1'b1);
    step();
    rv_seen = 0;
    for (int j = 3; j <= 118; j++) begin
      step();
      if (j == 19)  check("to_wait_first", dbg_state, ST_WAIT);
      if (j == 118) check("to_wait_last", dbg_state, ST_WAIT);
      if (bus.rsp_valid === 1'b1) rv_seen++;
    end
    check("to_no_early_rsp", rv_seen, 0);
    step();
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err",   bus.rsp_err, 1);
    step();
    check("to_post_valid", bus.rsp_valid, 0);
    check("to_err_hold",   bus.rsp_err, 1);

    // Reset during ACCESS
    bus.LOCK = 1'b1;
    repeat (3) step();
    check("rs_locked_before", bus.pll_locked, 1);
    send(1'b1, 6'h22, 8'h99, 1'b0);
    step();
    check("rs_acc_penable", bus.PENABLE, 1);
    rst = 1'b1;
    step();
    check("rs_psel",      bus.PSEL, 0);
    check("rs_penable",   bus.PENABLE, 0);
    check("rs_rsp_valid", bus.rsp_valid, 0);
    check("rs_cmd_ready", bus.cmd_ready, 0);
    check("rs_paddr",     bus.PADDR, 0);
    check("rs_pwdata",    bus.PWDATA, 0);
    check("rs_pwrite",    bus.PWRITE, 0);
    check("rs_rsp_rdata", bus.rsp_rdata, 0);
    check("rs_rsp_err",   bus.rsp_err, 0);
    check("rs_pll_locked", bus.pll_locked, 0);
    rst = 1'b0;
    step();
    check("rs_rel_ready", bus.cmd_ready, 1);
    rv_seen = 0;
    for (int j = 0; j < 5; j++) begin
      if (bus.rsp_valid === 1'b1) rv_seen++;
      step();
    end
    check("rs_no_rsp", rv_seen, 0);

    // BUSY gating
    bus.BUSY = 1'b1;
    step();
    step();
    check("bz_ready_still_1", bus.cmd_ready, 1);
    step();
    check("bz_ready_drop", bus.cmd_ready, 0);
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = 6'h2A;
    bus.cmd_wdata  = 8'h00;
    bus.cmd_relock = 1'b0;
    ps_seen  = 0;
    rdy_seen = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (bus.PSEL === 1'b1) ps_seen++;
      if (bus.cmd_ready === 1'b1) rdy_seen++;
    end
    check("bz_no_psel",  ps_seen, 0);
    check("bz_no_ready", rdy_seen, 0);
    bus.BUSY = 1'b0;
    step();
    step();
    check("bz_ready_late", bus.cmd_ready, 0);
    step();
    check("bz_ready_back", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    check("bz_setup_psel",    bus.PSEL, 1);
    check("bz_setup_penable", bus.PENABLE, 0);
    step();
    bus.PRDATA = 8'h77;
    check("bz_acc_paddr", bus.PADDR, 32'h2A);
    step();
    bus.PRDATA = 8'h00;
    check("bz_rsp_valid", bus.rsp_valid, 1);
    check("bz_rsp_rdata", bus.rsp_rdata, 32'h77);
    check("bz_rsp_err",   bus.rsp_err, 0);
    step();
    check("bz_post_valid", bus.rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ccc_apb_cfg_master.md
Name: ccc_apb_cfg_master

Overview:
- APB initiator that drives the dynamic-configuration APB port of a fabric CCC/PLL instance: PADDR[5:0], PWDATA[7:0], PRDATA[7:0], BUSY and LOCK.
- Lets fabric logic read and write CCC configuration bytes at run time.
- Optionally waits for the PLL to settle and re-lock after a write, with a timeout.
- Sits between a fabric controller (command/response handshake) and the CCC's PSEL/PENABLE/PWRITE/PADDR/PWDATA pins, in the same clock domain as the CCC PCLK.

Parameters:
- LOCK_TIMEOUT, 65535: max cycles spent in WAIT_LOCK before flagging an error; must be ≥1.
- SETTLE_CYCLES, 16: fixed wait after a relock access before LOCK is sampled; must be ≥ SYNC_STAGES+1.
- SYNC_STAGES, 2: synchronizer depth applied to the BUSY and LOCK inputs; must be ≥2.

Ports:
- PCLK, in, 1: single block clock; also drives the CCC PCLK.
- PRESET, in, 1: reset, synchronous, active-high.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, 6: CCC config register address.
- cmd_wdata, in, 8: write data.
- cmd_relock, in, 1: after the access, wait for PLL re-lock before responding.
- rsp_valid, out, 1: one-cycle response pulse.
- rsp_rdata, out, 8: read data; 0 for writes.
- rsp_err, out, 1: lock timeout; valid with rsp_valid.
- pll_locked, out, 1: synchronized LOCK.
- PSEL, out, 1: APB select to CCC.
- PENABLE, out, 1: APB enable to CCC.
- PWRITE, out, 1: APB direction.
- PADDR, out, 6: APB address.
- PWDATA, out, 8: APB write data.
- PRDATA, in, 8: APB read data from CCC.
- BUSY, in, 1: CCC busy; asynchronous, synchronized internally.
- LOCK, in, 1: PLL lock; asynchronous, synchronized internally.

Behaviour:
- All outputs are registered.
- Reset (PRESET=1 at an edge) puts the FSM in IDLE and drives every output to 0, including cmd_ready. Synchronizer flops and counters clear to 0.
- BUSY and LOCK each pass through a SYNC_STAGES flop chain, giving busy_s and lock_s. pll_locked = lock_s.
- FSM states: IDLE, SETUP, ACCESS, SETTLE, WAIT_LOCK, RESP.
- IDLE
  - cmd_ready = ~busy_s (registered, so it reflects busy_s of the previous cycle).
  - On accept: latch cmd_write, cmd_addr and cmd_wdata (or 0 for reads), and cmd_relock. Go to SETUP.
  - PADDR, PWRITE and PWDATA load at the same edge and hold until RESP ends.
- SETUP (1 cycle): PSEL=1, PENABLE=0, cmd_ready=0.
- ACCESS (1 cycle): PSEL=1, PENABLE=1.
  - The CCC has no PREADY, so ACCESS is always exactly 1 cycle.
  - For a read, PRDATA is captured into rsp_rdata at the edge leaving ACCESS; for a write, rsp_rdata := 0.
  - Next state: SETTLE if relock, else RESP.
- SETTLE: PSEL=PENABLE=0. Counter counts SETTLE_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK
  - Each cycle: if lock_s=1 and busy_s=0, go to RESP with rsp_err=0.
  - Otherwise increment the counter. When the counter reaches LOCK_TIMEOUT, go to RESP with rsp_err=1.
  - If success and timeout occur in the same cycle, success wins (err=0).
- RESP (1 cycle): rsp_valid=1 with rsp_rdata and rsp_err stable. Next state IDLE; rsp_valid returns to 0.
  - rsp_rdata and rsp_err hold their values until the next RESP. They are not cleared on leaving RESP.
- Latency without relock, command accepted at edge k:
  - SETUP occupies cycle k+1.
  - ACCESS occupies cycle k+2.
  - rsp_valid is high in cycle k+3.
  - cmd_ready is high again in cycle k+4 if busy_s=0.
- Only one command is outstanding at a time; cmd_valid is ignored outside IDLE.
- BUSY asserted while a command waits: cmd_ready stays 0 and no APB cycle starts. BUSY rising during SETUP or ACCESS does not abort the access.
- PRESET mid-operation: the next edge forces PSEL=PENABLE=0 and IDLE. No rsp_valid is produced for the aborted command.
- The APB protocol is never violated: PENABLE=1 only in the cycle immediately following a SETUP with PSEL=1.

Test Plan:
- Write: accept at edge k with addr 0x05, wdata 0xA5, relock 0.
  - Response: cycle k+1 PSEL=1/PENABLE=0; cycle k+2 PSEL=1/PENABLE=1 with PADDR=0x05, PWDATA=0xA5, PWRITE=1.
  - Then rsp_valid=1 in cycle k+3 with rsp_err=0, rsp_rdata=0x00.
- Read: addr 0x3F, PRDATA=0x5C during ACCESS.
  - Response: PWRITE=0, PWDATA=0x00, rsp_rdata=0x5C, rsp_valid 3 cycles after accept.
- Relock success: write with relock=1; LOCK drops 2 cycles after ACCESS and rises 40 cycles later, BUSY low.
  - Response: rsp_err=0, and rsp_valid asserts SYNC_STAGES+1 cycles after LOCK rises (no earlier than SETTLE end).
- Relock timeout: LOCK_TIMEOUT=100, LOCK held 0.
  - Response: rsp_valid with rsp_err=1 exactly 100 cycles after entering WAIT_LOCK.
- BUSY gating: BUSY=1 while cmd_valid=1.
  - Response: cmd_ready=0 and no PSEL. After BUSY falls, cmd_ready rises after sync latency plus 1 cycle, then normal access.
- Reset mid-access: PRESET=1 during ACCESS.
  - Response: next cycle PSEL=PENABLE=0 and all outputs 0; no rsp_valid. After PRESET release, cmd_ready=1 one cycle later.
